hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_md_timer.sv | 38 +++
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding,
// multiply/divide latency defaults and the busy-counter load helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDUSE  = 2'd1,
        MDBUSY = 2'd2
    } hz_state_t;

    localparam int unsigned MULT_CYCLES_DEF = 4;
    localparam int unsigned DIV_CYCLES_DEF  = 32;
    localparam int          CNT_W           = 6;

    // The counter runs from N-1 down to 0, so the unit is busy for exactly N cycles.
    function automatic logic [CNT_W-1:0] md_load_value(
        input logic        is_div,
        input int unsigned mult_cycles,
        input int unsigned div_cycles
    );
        int unsigned n;
        n = is_div ? div_cycles : mult_cycles;
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// HI/LO occupancy timer: loads the multiply/divide latency on start and
// counts down, holding busy high until the count expires.
module md_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    logic [CNT_W-1:0] md_cnt;

    // A start while already busy is dropped; the running operation keeps its count.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            md_cnt <= '0;
        end else if (busy) begin
            if (md_cnt == '0) begin
                busy <= 1'b0;
            end else begin
                md_cnt <= md_cnt - CNT_W'(1);
            end
        end else if (start) begin
            busy   <= 1'b1;
            md_cnt <= md_load_value(is_div, MULT_CYCLES, DIV_CYCLES);
        end
    end

    assign done = busy && (md_cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and HI/LO
// interlock. The multiply/divide interlock exists only with HAZARD_MULDIV_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_reads_hilo,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    input  logic       md_start,
    input  logic       md_is_div,
    output logic       stall,
    output logic       flush_if_id,
    output logic       bubble_id_ex,
    output logic       md_busy
);

    hz_state_t state, state_next;
    logic      load_use;
    logic      md_start_ok;
    logic      md_done;
    logic      hilo_stall;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

`ifdef HAZARD_MULDIV_EN
    logic timer_busy;

    assign md_start_ok = (state == RUN) && md_start;

    md_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_timer (
        .clk   (clk),
        .reset (reset),
        .start (md_start_ok),
        .is_div(md_is_div),
        .busy  (timer_busy),
        .done  (md_done)
    );

    assign md_busy    = timer_busy;
    assign hilo_stall = timer_busy && id_reads_hilo;
`else
    logic unused_md;

    assign unused_md   = ^{md_start, md_is_div, id_reads_hilo, 6'(MULT_CYCLES), 6'(DIV_CYCLES)};
    assign md_start_ok = 1'b0;
    assign md_done     = 1'b0;
    assign hilo_stall  = 1'b0;
    assign md_busy     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A taken branch squashes the ID instruction, so it overrides any stall request.
    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        unique case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (load_use) begin
                    stall        = 1'b1;
                    bubble_id_ex = 1'b1;
                    state_next   = LDUSE;
                end
                if (md_start_ok) begin
                    state_next = MDBUSY;
                end
            end
            LDUSE: begin
                state_next = RUN;
                if (ex_branch_taken) begin
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end
            end
            MDBUSY: begin
                if (md_done) begin
                    state_next = RUN;
                end
                if (ex_branch_taken) begin
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (load_use || hilo_stall) begin
                    stall        = 1'b1;
                    bubble_id_ex = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
        if (reset) begin
            stall        = 1'b0;
            flush_if_id  = 1'b0;
            bubble_id_ex = 1'b0;
        end
    end

endmodule
